// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: shared definitions for the instruction fetch unit.
//   - bus widths, PC increment, default reset PC
//   - FSM state encoding (ISSUE/WAIT/DROP/HALT)
//   - instruction buffer entry layout and depth
// Build option: MYRISCV_IFU_FIFO_EN selects a 2-entry instruction buffer;
// without it the buffer is a single output register.
package ifu_fetch_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [31:0] IFU_PC_INC           = 32'd4;
    localparam logic [31:0] IFU_DEFAULT_RESET_PC = 32'h8000_0000;

`ifdef MYRISCV_IFU_FIFO_EN
    localparam int IFU_IBUF_DEPTH = 2;
`else
    localparam int IFU_IBUF_DEPTH = 1;
`endif
    localparam int IFU_IBUF_CNT_W = $clog2(IFU_IBUF_DEPTH + 1);

    typedef enum logic [1:0] {
        IFU_ST_ISSUE = 2'd0,
        IFU_ST_WAIT  = 2'd1,
        IFU_ST_DROP  = 2'd2,
        IFU_ST_HALT  = 2'd3
    } ifu_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] ir;
        logic              err;
    } ibuf_entry_t;

    localparam int IFU_ENTRY_W = $bits(ibuf_entry_t);

endpackage

// File: rtl/ifu_fetch_ibuf.sv
// ifu_ibuf: DEPTH-entry synchronous FIFO of {pc, ir, err} fetch results.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   clear             drop all entries (wins over push)
//   push, push_*      write one entry at the tail
//   pop               remove the head entry (ignored when empty)
//   head_*            current head entry (contents meaningless when count==0)
//   count             number of valid entries
// Storage is a flat shift register: the head always sits in the lowest slot,
// so a pop is a right shift and a push lands at index count - pop.
module ifu_ibuf
    import ifu_fetch_pkg::*;
#(
    parameter int DEPTH = IFU_IBUF_DEPTH,
    parameter int CNT_W = IFU_IBUF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              push,
    input  logic [31:0]       push_pc,
    input  logic [31:0]       push_ir,
    input  logic              push_err,
    input  logic              pop,
    output logic [31:0]       head_pc,
    output logic [31:0]       head_ir,
    output logic              head_err,
    output logic [CNT_W-1:0]  count
);

    localparam int FLAT_W = DEPTH * IFU_ENTRY_W;

    logic [FLAT_W-1:0] mem_flat;
    logic [FLAT_W-1:0] mem_nxt;
    logic              do_pop;
    logic [CNT_W-1:0]  wr_idx;
    ibuf_entry_t       din;
    ibuf_entry_t       head;

    assign do_pop = pop && (count != '0);
    assign wr_idx = count - CNT_W'(do_pop);
    assign din    = '{pc: push_pc, ir: push_ir, err: push_err};

    always_comb begin
        mem_nxt = mem_flat;
        if (do_pop) begin
            mem_nxt = mem_nxt >> IFU_ENTRY_W;
        end
        if (push) begin
            mem_nxt[int'(wr_idx) * IFU_ENTRY_W +: IFU_ENTRY_W] = din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_flat <= '0;
            count    <= '0;
        end else if (clear) begin
            // Data is left in place; only the occupancy is dropped.
            count    <= '0;
        end else begin
            mem_flat <= mem_nxt;
            count    <= count + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

    assign head     = mem_flat[IFU_ENTRY_W-1:0];
    assign head_pc  = head.pc;
    assign head_ir  = head.ir;
    assign head_err = head.err;

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit.
// Generates sequential PCs, keeps at most one fetch outstanding on the
// pc_req/pc_rsp port, buffers returned words in ifu_ibuf and hands them to
// decode. A flush from execute redirects fetch and discards buffered and
// in-flight results.
// Build option: MYRISCV_IFU_FIFO_EN (2-entry buffer; default 1 entry).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   flush_vld, flush_pc           redirect pulse and target
//   pc_req_addr/vld/rdy           fetch request
//   pc_rsp_data/err/vld/rdy       fetch response
//   ifu_o_vld/rdy, ifu_o_pc/ir/err  instruction to decode (buffer head)
//   fsm_state                     current fetch FSM state (debug)
// Handshakes: a transfer happens on a cycle where vld & rdy are both high at
// posedge clk; a raised vld holds its payload until accepted, except that a
// flush may withdraw pc_req_vld.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFU_DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_vld,
    input  logic [31:0] flush_pc,
    output logic [31:0] pc_req_addr,
    output logic        pc_req_vld,
    input  logic        pc_req_rdy,
    input  logic [31:0] pc_rsp_data,
    input  logic        pc_rsp_err,
    input  logic        pc_rsp_vld,
    output logic        pc_rsp_rdy,
    output logic        ifu_o_vld,
    input  logic        ifu_o_rdy,
    output logic [31:0] ifu_o_pc,
    output logic [31:0] ifu_o_ir,
    output logic        ifu_o_err,
    output logic [1:0]  fsm_state
);

    ifu_state_e                state;
    ifu_state_e                state_nxt;
    logic [31:0]               fetch_pc;
    logic [31:0]               fetch_pc_nxt;
    logic [31:0]               req_pc;
    logic                      push;
    logic                      pop;
    logic                      space_ok;
    logic [IFU_IBUF_CNT_W-1:0] ibuf_count;

    assign ifu_o_vld   = (ibuf_count != '0);
    assign pop         = ifu_o_vld && ifu_o_rdy;
    assign pc_req_addr = fetch_pc;
    assign fsm_state   = state;

    // A request reserves a buffer slot for its response, so only issue when
    // the slot is guaranteed free by the time the response can arrive.
`ifdef MYRISCV_IFU_FIFO_EN
    assign space_ok = (ibuf_count < IFU_IBUF_CNT_W'(IFU_IBUF_DEPTH));
`else
    assign space_ok = (ibuf_count == '0) || pop;
`endif

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        pc_req_vld   = 1'b0;
        pc_rsp_rdy   = 1'b0;
        push         = 1'b0;

        case (state)
            IFU_ST_ISSUE: pc_req_vld = space_ok && !flush_vld && !rst;
            IFU_ST_WAIT,
            IFU_ST_DROP:  pc_rsp_rdy = !rst;
            default:      ;
        endcase

        if (flush_vld) begin
            // Redirect wins; a response still owed by memory is soaked up in DROP.
            fetch_pc_nxt = flush_pc;
            case (state)
                IFU_ST_WAIT,
                IFU_ST_DROP: state_nxt = (pc_rsp_vld && pc_rsp_rdy) ? IFU_ST_ISSUE
                                                                    : IFU_ST_DROP;
                default:     state_nxt = IFU_ST_ISSUE;
            endcase
        end else begin
            case (state)
                IFU_ST_ISSUE: begin
                    if (pc_req_vld && pc_req_rdy) begin
                        state_nxt = IFU_ST_WAIT;
                    end
                end
                IFU_ST_WAIT: begin
                    if (pc_rsp_vld && pc_rsp_rdy) begin
                        push = 1'b1;
                        if (pc_rsp_err) begin
                            state_nxt = IFU_ST_HALT;
                        end else begin
                            fetch_pc_nxt = req_pc + IFU_PC_INC;
                            state_nxt    = IFU_ST_ISSUE;
                        end
                    end
                end
                IFU_ST_DROP: begin
                    if (pc_rsp_vld && pc_rsp_rdy) begin
                        state_nxt = IFU_ST_ISSUE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IFU_ST_ISSUE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            if (pc_req_vld && pc_req_rdy) begin
                req_pc <= fetch_pc;
            end
        end
    end

    ifu_ibuf #(
        .DEPTH (IFU_IBUF_DEPTH),
        .CNT_W (IFU_IBUF_CNT_W)
    ) u_ibuf (
        .clk      (clk),
        .rst      (rst),
        .clear    (flush_vld),
        .push     (push),
        .push_pc  (req_pc),
        .push_ir  (pc_rsp_data),
        .push_err (pc_rsp_err),
        .pop      (pop),
        .head_pc  (ifu_o_pc),
        .head_ir  (ifu_o_ir),
        .head_err (ifu_o_err),
        .count    (ibuf_count)
    );

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
`ifdef MYRISCV_IFU_FIFO_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk;
    logic        rst;
    logic        flush_vld;
    logic [31:0] flush_pc;
    logic [31:0] pc_req_addr;
    logic        pc_req_vld;
    logic        pc_req_rdy;
    logic [31:0] pc_rsp_data;
    logic        pc_rsp_err;
    logic        pc_rsp_vld;
    logic        pc_rsp_rdy;
    logic        ifu_o_vld;
    logic        ifu_o_rdy;
    logic [31:0] ifu_o_pc;
    logic [31:0] ifu_o_ir;
    logic        ifu_o_err;
    logic [1:0]  fsm_state;

    ifu_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_vld   (flush_vld),
        .flush_pc    (flush_pc),
        .pc_req_addr (pc_req_addr),
        .pc_req_vld  (pc_req_vld),
        .pc_req_rdy  (pc_req_rdy),
        .pc_rsp_data (pc_rsp_data),
        .pc_rsp_err  (pc_rsp_err),
        .pc_rsp_vld  (pc_rsp_vld),
        .pc_rsp_rdy  (pc_rsp_rdy),
        .ifu_o_vld   (ifu_o_vld),
        .ifu_o_rdy   (ifu_o_rdy),
        .ifu_o_pc    (ifu_o_pc),
        .ifu_o_ir    (ifu_o_ir),
        .ifu_o_err   (ifu_o_err),
        .fsm_state   (fsm_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters / check ----------------
    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] ir_of(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // ---------------- memory responder ----------------
    int          mem_lat = 1;
    logic        mem_err_en = 1'b0;
    logic [31:0] mem_err_addr = 32'h0;
    logic        mem_busy;
    logic [31:0] mem_addr;
    int          mem_cnt;

    initial begin : mem_proc
        logic        r, rq, rs;
        logic [31:0] a;
        pc_rsp_vld  = 1'b0;
        pc_rsp_data = 32'h0;
        pc_rsp_err  = 1'b0;
        mem_busy    = 1'b0;
        mem_addr    = 32'h0;
        mem_cnt     = 0;
        forever begin
            @(negedge clk);
            r  = rst;
            rq = pc_req_vld && pc_req_rdy;
            rs = pc_rsp_vld && pc_rsp_rdy;
            a  = pc_req_addr;
            @(posedge clk);
            #1;
            if (r) begin
                mem_busy   = 1'b0;
                pc_rsp_vld = 1'b0;
            end else begin
                if (rs) begin
                    pc_rsp_vld = 1'b0;
                    mem_busy   = 1'b0;
                end
                if (rq) begin
                    mem_busy = 1'b1;
                    mem_addr = a;
                    mem_cnt  = mem_lat;
                end
                if (mem_busy && !pc_rsp_vld) begin
                    mem_cnt--;
                    if (mem_cnt <= 0) begin
                        pc_rsp_vld  = 1'b1;
                        pc_rsp_data = ir_of(mem_addr);
                        pc_rsp_err  = mem_err_en && (mem_addr == mem_err_addr);
                    end
                end
            end
        end
    end

    // ---------------- scoreboard / model ----------------
    // Entries are packed {pc, ir, err}.
    logic [64:0] exp_q[$];
    logic [64:0] dec_log[$];
    logic [31:0] req_log[$];
    logic [31:0] m_pc;
    logic [31:0] m_opc;
    bit          m_outst, m_disc, m_halt, rst_seen;

    initial begin : compare_proc
        bit          have, pop, space, e_req, rq, rs;
        logic [64:0] h;
        m_pc = RESET_PC; m_opc = 32'h0;
        m_outst = 0; m_disc = 0; m_halt = 0; rst_seen = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (rst_seen) begin
                    check("rst_pc_req_vld",  pc_req_vld,  32'd0);
                    check("rst_pc_rsp_rdy",  pc_rsp_rdy,  32'd0);
                    check("rst_ifu_o_vld",   ifu_o_vld,   32'd0);
                    check("rst_ifu_o_pc",    ifu_o_pc,    32'd0);
                    check("rst_ifu_o_ir",    ifu_o_ir,    32'd0);
                    check("rst_ifu_o_err",   ifu_o_err,   32'd0);
                    check("rst_pc_req_addr", pc_req_addr, RESET_PC);
                    check("rst_fsm_state",   fsm_state,   32'd0);
                end
                rst_seen = 1;
                exp_q.delete();
                m_pc = RESET_PC; m_outst = 0; m_disc = 0; m_halt = 0;
            end else begin
                rst_seen = 0;
                have = (exp_q.size() > 0);
                check("ifu_o_vld", ifu_o_vld, have);
                if (have) begin
                    h = exp_q[0];
                    check("ifu_o_pc",  ifu_o_pc,  h[64:33]);
                    check("ifu_o_ir",  ifu_o_ir,  h[32:1]);
                    check("ifu_o_err", ifu_o_err, h[0]);
                end
                check("pc_rsp_rdy", pc_rsp_rdy, m_outst);
                pop   = have && ifu_o_rdy;
                space = (DEPTH == 2) ? (exp_q.size() < 2) : (exp_q.size() == 0 || pop);
                e_req = !m_outst && !m_halt && !flush_vld && space;
                check("pc_req_vld", pc_req_vld, e_req);
                if (e_req) check("pc_req_addr", pc_req_addr, m_pc);

                if (ifu_o_vld && ifu_o_rdy) dec_log.push_back({ifu_o_pc, ifu_o_ir, ifu_o_err});
                if (pc_req_vld && pc_req_rdy) req_log.push_back(pc_req_addr);

                rq = e_req && pc_req_rdy;
                rs = m_outst && pc_rsp_vld;
                if (pop) void'(exp_q.pop_front());
                if (flush_vld) begin
                    exp_q.delete();
                    m_pc   = flush_pc;
                    m_halt = 0;
                    if (m_outst && !rs) m_disc = 1;
                    else m_outst = 0;
                end else begin
                    if (rq) begin
                        m_outst = 1; m_disc = 0; m_opc = m_pc;
                    end
                    if (rs) begin
                        m_outst = 0;
                        if (!m_disc) begin
                            exp_q.push_back({m_opc, ir_of(m_opc), pc_rsp_err});
                            if (pc_rsp_err) m_halt = 1;
                            else m_pc = m_opc + 32'd4;
                        end
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        req_log.delete();
        dec_log.delete();
        rst = 1'b0;
    endtask

    task automatic flush(input logic [31:0] pc);
        flush_vld = 1'b1;
        flush_pc  = pc;
        tick(1);
        flush_vld = 1'b0;
    endtask

    task automatic chk_req(input string nm, input int idx, input logic [31:0] exp);
        if (idx < req_log.size()) check(nm, req_log[idx], exp);
        else check({nm, "_missing"}, req_log.size(), idx + 1);
    endtask

    task automatic chk_dec(input string nm, input int idx, input logic [31:0] pc,
                           input logic [31:0] ir, input logic err);
        logic [64:0] e;
        if (idx < dec_log.size()) begin
            e = dec_log[idx];
            check({nm, "_pc"},  e[64:33], pc);
            check({nm, "_ir"},  e[32:1],  ir);
            check({nm, "_err"}, e[0],     err);
        end else begin
            check({nm, "_missing"}, dec_log.size(), idx + 1);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        chk_cnt++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    // ---------------- directed stimulus ----------------
    initial begin : stim
        int  n, m;
        bit  found;
        rst        = 1'b1;
        flush_vld  = 1'b0;
        flush_pc   = 32'h0;
        ifu_o_rdy  = 1'b1;
        pc_req_rdy = 1'b1;

        // T1: sequential fetch, zero-wait memory, decode always ready
        mem_lat = 1;
        do_reset();
        tick(8);
        chk_req("t1_req0", 0, 32'h8000_0000);
        chk_req("t1_req1", 1, 32'h8000_0004);
        chk_req("t1_req2", 2, 32'h8000_0008);
        chk_dec("t1_dec0", 0, 32'h8000_0000, 32'h5EAD_BEEF, 1'b0);
        chk_dec("t1_dec1", 1, 32'h8000_0004, 32'h5EAD_BEEB, 1'b0);
        chk_dec("t1_dec2", 2, 32'h8000_0008, 32'h5EAD_BEE7, 1'b0);
        // request port back-pressure: vld/addr must hold
        pc_req_rdy = 1'b0;
        tick(4);
        pc_req_rdy = 1'b1;
        tick(6);

        // T2: decode stall fills exactly DEPTH entries
        ifu_o_rdy = 1'b0;
        do_reset();
        tick(10);
        check("t2_req_count", req_log.size(), DEPTH);
        check("t2_dec_count", dec_log.size(), 32'd0);
        check("t2_req_vld_stalled", pc_req_vld, 32'd0);
        ifu_o_rdy = 1'b1;
        tick(12);
        chk_dec("t2_dec0", 0, 32'h8000_0000, 32'h5EAD_BEEF, 1'b0);
        chk_dec("t2_dec1", 1, 32'h8000_0004, 32'h5EAD_BEEB, 1'b0);
        chk_dec("t2_dec2", 2, 32'h8000_0008, 32'h5EAD_BEE7, 1'b0);

        // T3: flush while waiting, response 3 cycles later is dropped
        mem_lat = 3;
        do_reset();
        tick(1);
        flush(32'h8000_0100);
        tick(10);
        chk_req("t3_req0", 0, 32'h8000_0000);
        chk_req("t3_req1", 1, 32'h8000_0100);
        chk_dec("t3_dec0", 0, 32'h8000_0100, 32'h5EAD_BFEF, 1'b0);

        // T4: flush coincident with a response handshake
        mem_lat   = 1;
        ifu_o_rdy = 1'b0;
        do_reset();
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (pc_rsp_vld && (ifu_o_vld || DEPTH == 1)) found = 1;
            else tick(1);
        end
        check("t4_rsp_seen", found, 32'd1);
        n = req_log.size();
        flush(32'h8000_0200);
        ifu_o_rdy = 1'b1;
        tick(8);
        chk_req("t4_req_after_flush", n, 32'h8000_0200);
        chk_dec("t4_dec0", 0, 32'h8000_0200, 32'h5EAD_BCEF, 1'b0);

        // T5: bus error halts fetch; flush resumes
        mem_err_en   = 1'b1;
        mem_err_addr = 32'h8000_0008;
        do_reset();
        tick(14);
        check("t5_req_count", req_log.size(), 32'd3);
        check("t5_dec_count", dec_log.size(), 32'd3);
        chk_dec("t5_dec1", 1, 32'h8000_0004, 32'h5EAD_BEEB, 1'b0);
        chk_dec("t5_dec2", 2, 32'h8000_0008, 32'h5EAD_BEE7, 1'b1);
        check("t5_halted_req_vld", pc_req_vld, 32'd0);
        mem_err_en = 1'b0;
        n = req_log.size();
        m = dec_log.size();
        flush(32'h8000_0000);
        tick(8);
        chk_req("t5_resume_req", n, 32'h8000_0000);
        chk_dec("t5_resume_dec", m, 32'h8000_0000, 32'h5EAD_BEEF, 1'b0);

        // T6: reset while waiting for a response
        mem_lat = 3;
        do_reset();
        tick(1);
        do_reset();
        tick(8);
        chk_req("t6_req0", 0, RESET_PC);
        chk_dec("t6_dec0", 0, 32'h8000_0000, 32'h5EAD_BEEF, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
